// File: rtl/wt_fetch.sv
// Weight-fetch sequencer: streams a contiguous range of kernel words from a
// dual-port registered ROM as kernel pairs on a valid/ready stream.
module wt_fetch #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 144,
  parameter int DEPTH      = 76
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] num_kernels,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] rom_addr_a,
  output logic [ADDR_WIDTH-1:0] rom_addr_b,
  input  logic [DATA_WIDTH-1:0] rom_q_a,
  input  logic [DATA_WIDTH-1:0] rom_q_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_wt_a,
  output logic [DATA_WIDTH-1:0] out_wt_b,
  output logic                  out_b_valid,
  output logic                  out_last
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] cur, remaining;
  logic [ADDR_WIDTH-1:0] hold_a, hold_b;
  logic [ADDR_WIDTH-1:0] issue_addr_b;
  logic [ADDR_WIDTH:0]   end_addr;
  logic                  range_bad;
  logic                  last_pair, pair_b_valid;

  logic                  inflight, inflight_b_valid, inflight_last;

  logic [DATA_WIDTH-1:0] fifo_a [2];
  logic [DATA_WIDTH-1:0] fifo_b [2];
  logic [1:0]            fifo_b_valid, fifo_last;
  logic [1:0]            count;
  logic                  wr_ptr, rd_ptr;

  logic                  issue, issue_ok, push, pop;
  logic                  err_q;

  assign end_addr     = {1'b0, base_addr} + {1'b0, num_kernels};
  assign range_bad    = end_addr > (ADDR_WIDTH + 1)'(DEPTH);
  assign last_pair    = remaining <= ADDR_WIDTH'(2);
  assign pair_b_valid = remaining >= ADDR_WIDTH'(2);

  // A lone final kernel re-reads its own address on port B so the ROM never
  // sees an address past the requested range.
  assign issue_addr_b = pair_b_valid ? cur + ADDR_WIDTH'(1) : cur;

  assign out_valid = count != 2'd0;
  assign pop       = out_valid & out_ready;
  assign push      = inflight;

  // Buffer occupancy once the in-flight read lands must stay within 2 entries.
  assign issue_ok = ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (range_bad || num_kernels == '0) state_next = DONE;
          else                                state_next = FETCH;
        end
      end
      FETCH: begin
        if (issue_ok) begin
          issue = 1'b1;
          if (last_pair) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight && (count == 2'd0 || (count == 2'd1 && pop)))
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign rom_addr_a  = issue ? cur : hold_a;
  assign rom_addr_b  = issue ? issue_addr_b : hold_b;
  assign busy        = state != IDLE;
  assign done        = state == DONE;
  assign err         = err_q;
  assign out_wt_a    = fifo_a[rd_ptr];
  assign out_wt_b    = fifo_b[rd_ptr];
  assign out_b_valid = out_valid & fifo_b_valid[rd_ptr];
  assign out_last    = out_valid & fifo_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      remaining <= '0;
      hold_a    <= '0;
      hold_b    <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        cur       <= base_addr;
        remaining <= num_kernels;
        err_q     <= range_bad;
      end else if (issue) begin
        cur       <= cur + ADDR_WIDTH'(2);
        remaining <= last_pair ? '0 : remaining - ADDR_WIDTH'(2);
        hold_a    <= rom_addr_a;
        hold_b    <= rom_addr_b;
      end
    end
  end

  // Pair metadata travels alongside the ROM read so it lands with the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight         <= 1'b0;
      inflight_b_valid <= 1'b0;
      inflight_last    <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_b_valid <= pair_b_valid;
        inflight_last    <= last_pair;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_a[0]    <= '0;
      fifo_a[1]    <= '0;
      fifo_b[0]    <= '0;
      fifo_b[1]    <= '0;
      fifo_b_valid <= '0;
      fifo_last    <= '0;
      count        <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
    end else begin
      if (push) begin
        fifo_a[wr_ptr]       <= rom_q_a;
        fifo_b[wr_ptr]       <= rom_q_b;
        fifo_b_valid[wr_ptr] <= inflight_b_valid;
        fifo_last[wr_ptr]    <= inflight_last;
        wr_ptr               <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
